// File: rtl/home_event_scheduler_pkg.sv
// Shared types and helpers for the home event scheduler and the actuator decoder.
//   state_code_e : externally visible 3-bit state code (IDLE, ALARM0..3, HEAT, COOL)
//   fsm_e        : internal scheduler FSM states
//   code2onehot  : maps a state code to the 6-bit actuator enable vector
package home_auto_pkg;

  localparam int NUM_REQ   = 4;
  localparam int NUM_CODES = 7;

  typedef enum logic [2:0] {
    CODE_IDLE   = 3'd0,
    CODE_ALARM0 = 3'd1,
    CODE_ALARM1 = 3'd2,
    CODE_ALARM2 = 3'd3,
    CODE_ALARM3 = 3'd4,
    CODE_HEAT   = 3'd5,
    CODE_COOL   = 3'd6
  } state_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HOLD,
    ST_HEAT,
    ST_COOL
  } fsm_e;

  // IDLE and the unused code 7 both map to all-zero so at most one enable is ever set.
  function automatic logic [5:0] code2onehot(input logic [2:0] code);
    logic [5:0] oh;
    oh = '0;
    if (code != 3'd0 && code < 3'(NUM_CODES))
      oh[code - 3'd1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/home_event_scheduler_if.sv
// Actuator-side bus of the home event scheduler.
//   act_valid  : grant offered to the actuator driver
//   act_ready  : driver accepts the grant when act_valid & act_ready
//   grant_id   : index of the granted requester
//   state_code : 3-bit scheduler state code
//   act_onehot : one-hot actuator enables derived from state_code
// master = scheduler side, slave = actuator driver side.
interface home_event_scheduler_if;
  logic       act_valid;
  logic       act_ready;
  logic [1:0] grant_id;
  logic [2:0] state_code;
  logic [5:0] act_onehot;

  modport master (
    output act_valid,
    output grant_id,
    output state_code,
    output act_onehot,
    input  act_ready
  );

  modport slave (
    input  act_valid,
    input  grant_id,
    input  state_code,
    input  act_onehot,
    output act_ready
  );
endinterface

// File: rtl/home_event_scheduler_arbiter.sv
// Combinational winner selection among the four pending sensor events.
//   pending   : captured, not-yet-accepted events
//   rr_ptr    : round-robin start index (ignored when RR_EN = 0)
//   win_valid : at least one event pending
//   win_id    : selected requester index
// RR_EN = 0 gives fixed priority with index 0 highest; RR_EN = 1 picks the first
// pending index at or after rr_ptr, wrapping modulo 4.
module home_prio_arbiter
  import home_auto_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [1:0]         rr_ptr,
  output logic               win_valid,
  output logic [1:0]         win_id
);

  logic [1:0] start;
  logic [1:0] idx;

  always_comb begin
    win_valid = |pending;
    win_id    = 2'd0;
    idx       = 2'd0;
    start     = RR_EN ? rr_ptr : 2'd0;
    // Scan from the farthest offset down so the nearest pending index is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (pending[idx])
        win_id = idx;
    end
  end

endmodule

// File: rtl/home_event_scheduler.sv
// Home event scheduler: captures sensor event edges, grants one event at a time
// to the actuator path over a valid/ready handshake, holds the actuator for
// HOLD_CYCLES after each accept, and runs heat/cool control when no event waits.
//   clk     : clock, all state on the rising edge
//   rst     : asynchronous active-low reset
//   req     : level sensor inputs (fire, intrusion, flood, gas)
//   temp    : current temperature, unsigned
//   pending : captured, not-yet-accepted events
//   act     : actuator bus (act_valid, act_ready, grant_id, state_code, act_onehot)
module home_event_scheduler
  import home_auto_pkg::*;
#(
  parameter int unsigned TEMP_W      = 6,
  parameter int unsigned TEMP_HI     = 30,
  parameter int unsigned TEMP_LO     = 15,
  parameter int unsigned HYST        = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter bit          RR_EN       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [TEMP_W-1:0]     temp,
  output logic [NUM_REQ-1:0]    pending,
  home_event_scheduler_if.master act
);

  // Climate thresholds evaluated in 32 bits so TEMP_LO + HYST cannot wrap.
  localparam int unsigned LO_EXIT   = TEMP_LO + HYST;
  localparam int unsigned HI_EXIT   = TEMP_HI - HYST;
  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] set_vec, clr_vec;
  fsm_e               state_q, state_d;
  logic [1:0]         gid_q, gid_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         rr_ptr_q;
  logic               valid_q, valid_d;
  logic [2:0]         code_q, code_d;
  logic [5:0]         onehot_q;
  logic               win_valid;
  logic [1:0]         win_id;
  logic               accept;
  logic [31:0]        temp_u;

  assign temp_u = 32'(temp);
  // act_valid is only ever high in GRANT, so act_ready elsewhere has no effect.
  assign accept = valid_q & act.act_ready;

  home_prio_arbiter #(
    .RR_EN (RR_EN)
  ) u_arb (
    .pending   (pending_q),
    .rr_ptr    (rr_ptr_q),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  // Event capture: a new rising edge beats a same-cycle clear of that bit.
  always_comb begin
    set_vec   = req & ~req_q;
    clr_vec   = accept ? (NUM_REQ'(1) << gid_q) : '0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANT;
          gid_d   = win_id;
        end else if (temp_u > TEMP_HI) begin
          state_d = ST_COOL;
        end else if (temp_u < TEMP_LO) begin
          state_d = ST_HEAT;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0)
          state_d = ST_IDLE;
        else
          cnt_d = cnt_q - 8'd1;
      end
      ST_HEAT: begin
        if (temp_u >= LO_EXIT || (|pending_q))
          state_d = ST_IDLE;
      end
      ST_COOL: begin
        if (temp_u <= HI_EXIT || (|pending_q))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state, registered alongside it
  always_comb begin
    valid_d = (state_d == ST_GRANT);
    code_d  = CODE_IDLE;
    case (state_d)
      ST_GRANT, ST_HOLD: code_d = {1'b0, gid_d} + 3'd1;
      ST_HEAT:           code_d = CODE_HEAT;
      ST_COOL:           code_d = CODE_COOL;
      default:           code_d = CODE_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= '0;
      pending_q <= '0;
      state_q   <= ST_IDLE;
      gid_q     <= 2'd0;
      cnt_q     <= 8'd0;
      rr_ptr_q  <= 2'd0;
      valid_q   <= 1'b0;
      code_q    <= 3'd0;
      onehot_q  <= 6'd0;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      state_q   <= state_d;
      gid_q     <= gid_d;
      cnt_q     <= cnt_d;
      if (accept)
        rr_ptr_q <= gid_q + 2'd1;
      valid_q   <= valid_d;
      code_q    <= code_d;
      onehot_q  <= code2onehot(code_d);
    end
  end

  assign pending        = pending_q;
  assign act.act_valid  = valid_q;
  assign act.grant_id   = gid_q & {2{code_q != 3'd0 && code_q < 3'd5}};
  assign act.state_code = code_q;
  assign act.act_onehot = onehot_q;

endmodule

// File: tb/tb_home_event_scheduler.sv
module tb_home_event_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic [5:0] temp = 6'd20;
  logic [3:0] pending;
  logic [3:0] req_rr = 4'd0;
  logic [5:0] temp_rr = 6'd20;
  logic [3:0] pending_rr;

  int total = 0;
  int bad = 0;
  int rr_acc = 0;

  // {grant_id, state_code, act_onehot}
  logic [10:0] q_main[$];
  logic [10:0] q_rr[$];

  home_event_scheduler_if m_if();
  home_event_scheduler_if rr_if();

  home_event_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .temp    (temp),
    .pending (pending),
    .act     (m_if)
  );

  home_event_scheduler #(
    .RR_EN       (1'b1),
    .HOLD_CYCLES (2)
  ) dut_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_rr),
    .temp    (temp_rr),
    .pending (pending_rr),
    .act     (rr_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_code(input logic [2:0] c, input int budget, input string nm);
    int n;
    n = 0;
    while (m_if.state_code !== c && n < budget) begin
      tick(1);
      n++;
    end
    chk(nm, 32'(m_if.state_code), 32'(c));
  endtask

  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst && m_if.act_valid && m_if.act_ready) begin
        if (q_main.size() == 0) begin
          chk("main_unexpected_grant", 32'({m_if.grant_id, m_if.state_code, m_if.act_onehot}), 32'h7ff);
        end else begin
          e = q_main.pop_front();
          chk("main_grant", 32'({m_if.grant_id, m_if.state_code, m_if.act_onehot}), 32'(e));
        end
      end
      if (rst && rr_if.act_valid && rr_if.act_ready) begin
        rr_acc++;
        if (q_rr.size() == 0) begin
          chk("rr_unexpected_grant", 32'({rr_if.grant_id, rr_if.state_code, rr_if.act_onehot}), 32'h7ff);
        end else begin
          e = q_rr.pop_front();
          chk("rr_grant", 32'({rr_if.grant_id, rr_if.state_code, rr_if.act_onehot}), 32'(e));
        end
      end
    end
  endtask

  initial begin
    int n;
    m_if.act_ready  = 1'b1;
    rr_if.act_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    #2 rst = 1'b0;
    #10;
    chk("rst_valid", 32'(m_if.act_valid), 32'd0);
    chk("rst_code", 32'(m_if.state_code), 32'd0);
    chk("rst_onehot", 32'(m_if.act_onehot), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_gid", 32'(m_if.grant_id), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(2);
    chk("idle_code", 32'(m_if.state_code), 32'd0);

    // Two simultaneous rises: fixed priority grants 1 then 2
    q_main.push_back({2'd1, 3'd2, 6'b000010});
    q_main.push_back({2'd2, 3'd3, 6'b000100});
    req = 4'b0110;
    tick(1);
    chk("t1_pending", 32'(pending), 32'h6);
    chk("t1_valid_lat", 32'(m_if.act_valid), 32'd0);
    tick(1);
    chk("t1_valid", 32'(m_if.act_valid), 32'd1);
    chk("t1_gid", 32'(m_if.grant_id), 32'd1);
    tick(1);
    chk("t1_hold_valid", 32'(m_if.act_valid), 32'd0);
    chk("t1_hold_code", 32'(m_if.state_code), 32'd2);
    chk("t1_hold_pending", 32'(pending), 32'h4);
    req = 4'b0000;
    wait_code(3'd3, 40, "t1_second_grant");
    wait_code(3'd0, 40, "t1_back_idle");

    // Back-pressure: grant held stable for 5 cycles, accepted on the 6th
    m_if.act_ready = 1'b0;
    q_main.push_back({2'd0, 3'd1, 6'b000001});
    req = 4'b0001;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stable", 32'({m_if.act_valid, m_if.grant_id, m_if.state_code}), 32'({1'b1, 2'd0, 3'd1}));
      if (i < 4) tick(1);
    end
    m_if.act_ready = 1'b1;
    tick(1);
    chk("t2_accepted", 32'({m_if.act_valid, m_if.state_code, pending}), 32'({1'b0, 3'd1, 4'd0}));
    // Hold for 16 cycles including the accept edge
    for (int i = 1; i < 16; i++) begin
      tick(1);
      chk("t3_hold_code", 32'(m_if.state_code), 32'd1);
    end
    tick(1);
    chk("t3_idle_at_end", 32'(m_if.state_code), 32'd0);
    req = 4'b0000;

    // Climate control with hysteresis
    temp = 6'd31;
    tick(1);
    chk("t4_cool", 32'(m_if.state_code), 32'd6);
    chk("t4_cool_oh", 32'(m_if.act_onehot), 32'h20);
    temp = 6'd29;
    tick(1);
    chk("t4_cool_stay", 32'(m_if.state_code), 32'd6);
    temp = 6'd28;
    tick(1);
    chk("t4_cool_exit", 32'(m_if.state_code), 32'd0);
    temp = 6'd30;
    tick(1);
    chk("t4_hi_boundary", 32'(m_if.state_code), 32'd0);
    temp = 6'd15;
    tick(1);
    chk("t4_lo_boundary", 32'(m_if.state_code), 32'd0);
    temp = 6'd14;
    tick(1);
    chk("t4_heat", 32'(m_if.state_code), 32'd5);
    chk("t4_heat_oh", 32'(m_if.act_onehot), 32'h10);
    temp = 6'd16;
    tick(1);
    chk("t4_heat_stay", 32'(m_if.state_code), 32'd5);
    temp = 6'd17;
    tick(1);
    chk("t4_heat_exit", 32'(m_if.state_code), 32'd0);
    temp = 6'd20;

    // Event during HEAT: IDLE next cycle, then grant code 4
    temp = 6'd10;
    tick(1);
    chk("t5_heat", 32'(m_if.state_code), 32'd5);
    q_main.push_back({2'd3, 3'd4, 6'b001000});
    req = 4'b1000;
    tick(1);
    chk("t5_pending", 32'({pending, m_if.state_code}), 32'({4'b1000, 3'd5}));
    tick(1);
    chk("t5_idle", 32'(m_if.state_code), 32'd0);
    tick(1);
    chk("t5_grant", 32'({m_if.act_valid, m_if.grant_id, m_if.state_code}), 32'({1'b1, 2'd3, 3'd4}));
    temp = 6'd20;
    req = 4'b0000;
    wait_code(3'd0, 40, "t5_back_idle");

    // Reset while a grant is offered
    m_if.act_ready = 1'b0;
    req = 4'b0110;
    tick(2);
    chk("t6_grant", 32'({m_if.act_valid, m_if.grant_id}), 32'({1'b1, 2'd1}));
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_async", 32'({m_if.act_valid, m_if.state_code, m_if.act_onehot, pending}), 32'd0);
    req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b1;
    m_if.act_ready = 1'b1;
    tick(2);
    chk("t6_after_rel", 32'({pending, m_if.state_code, m_if.act_valid}), 32'd0);

    // Round-robin: 1111 then bit 0 re-pulsed after its first grant
    q_rr.push_back({2'd0, 3'd1, 6'b000001});
    q_rr.push_back({2'd1, 3'd2, 6'b000010});
    q_rr.push_back({2'd2, 3'd3, 6'b000100});
    q_rr.push_back({2'd3, 3'd4, 6'b001000});
    q_rr.push_back({2'd0, 3'd1, 6'b000001});
    req_rr = 4'b1111;
    tick(1);
    chk("rr_pending", 32'(pending_rr), 32'hf);
    tick(2);
    req_rr = 4'b0000;
    tick(1);
    req_rr = 4'b1111;
    n = 0;
    while (rr_acc < 5 && n < 200) begin
      tick(1);
      n++;
    end
    chk("rr_accept_count", 32'(rr_acc), 32'd5);
    chk("rr_hold_code", 32'(rr_if.state_code), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rr_rst_async", 32'({rr_if.act_valid, rr_if.state_code, rr_if.act_onehot, pending_rr}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    req_rr = 4'b0000;
    tick(2);
    chk("rr_after_rel", 32'({pending_rr, rr_if.state_code}), 32'd0);

    chk("main_queue_drained", 32'(q_main.size()), 32'd0);
    chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
